// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: oversampled UART receive controller.
// Drives an external shift register through rx_sync, shift_en and latch_valid.
module uart_rx_ctrl #(
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic baud_tick,
    input  logic rx,
    input  logic ack,
    output logic rx_sync,
    output logic shift_en,
    output logic latch_valid,
    output logic data_ready,
    output logic busy,
    output logic frame_err,
    output logic overrun
);
    localparam int TW = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0] T_HALF = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] T_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [3:0]    B_LAST = 4'(DATA_BITS - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state, state_n;
    logic [TW-1:0] tcnt, tcnt_n;
    logic [3:0]    bcnt, bcnt_n;
    logic          rx_meta, rx_prev;
    logic          start_eval, bit_eval, stop_eval;
    logic          shift_n, latch_n, ferr_n, ready_n, ovr_n;

    assign start_eval = (state == START) && baud_tick && (tcnt == T_HALF);
    assign bit_eval   = (state == DATA)  && baud_tick && (tcnt == T_LAST);
    assign stop_eval  = (state == STOP)  && baud_tick && (tcnt == T_LAST);
    assign busy       = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            tcnt        <= '0;
            bcnt        <= '0;
            rx_meta     <= 1'b1;
            rx_sync     <= 1'b1;
            rx_prev     <= 1'b1;
            shift_en    <= 1'b0;
            latch_valid <= 1'b0;
            frame_err   <= 1'b0;
            data_ready  <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            state       <= state_n;
            tcnt        <= tcnt_n;
            bcnt        <= bcnt_n;
            rx_meta     <= rx;
            rx_sync     <= rx_meta;
            rx_prev     <= rx_sync;
            shift_en    <= shift_n;
            latch_valid <= latch_n;
            frame_err   <= ferr_n;
            data_ready  <= ready_n;
            overrun     <= ovr_n;
        end
    end

    always_comb begin
        state_n = state;
        tcnt_n  = baud_tick ? tcnt + 1'b1 : tcnt;
        bcnt_n  = bcnt;
        unique case (state)
            IDLE: begin
                tcnt_n = '0;
                bcnt_n = '0;
                // a start needs a real falling edge, not a line stuck low
                if (rx_prev && !rx_sync)
                    state_n = START;
            end
            START: begin
                if (start_eval) begin
                    state_n = rx_sync ? IDLE : DATA;
                    tcnt_n  = '0;
                end
            end
            DATA: begin
                if (bit_eval) begin
                    tcnt_n = '0;
                    if (bcnt == B_LAST) begin
                        state_n = STOP;
                        bcnt_n  = '0;
                    end else begin
                        bcnt_n = bcnt + 4'd1;
                    end
                end
            end
            STOP: begin
                if (stop_eval) begin
                    state_n = IDLE;
                    tcnt_n  = '0;
                end
            end
        endcase
    end

    always_comb begin
        shift_n = bit_eval;
        latch_n = stop_eval && rx_sync;
        ferr_n  = stop_eval && !rx_sync;
        ready_n = data_ready;
        ovr_n   = overrun;
        if (data_ready && ack) begin
            ready_n = 1'b0;
            ovr_n   = 1'b0;
        end
        // newest byte always wins; overrun only if the old one was not taken
        if (latch_n) begin
            ready_n = 1'b1;
            if (data_ready && !ack)
                ovr_n = 1'b1;
        end
    end
endmodule
